// File: rtl/ula_wb.sv
// Write-back stage for the ULA: one pending-entry skid register, an 8-entry
// register file with forwarding read ports, architectural flags and a retire counter.
module ula_wb #(
  parameter int bits = 16
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            IN_VALID,
  output logic            IN_READY,
  input  logic [bits-1:0] RESU,
  input  logic            O,
  input  logic            C,
  input  logic            S,
  input  logic            Z,
  input  logic [2:0]      RD,
  input  logic            WE,
  input  logic [3:0]      FMASK,
  input  logic            HOLD,
  input  logic [2:0]      RA1,
  input  logic [2:0]      RA2,
  output logic [bits-1:0] RD1,
  output logic [bits-1:0] RD2,
  output logic [3:0]      FLAGS,
  output logic            WB_VALID,
  output logic [15:0]     WB_COUNT
);

  // Handshake: a result transfers on a rising edge where IN_VALID && IN_READY;
  // the pending entry retires on any edge where WB_VALID is high.
  logic            pvalid_q,  pvalid_d;
  logic [bits-1:0] p_resu_q,  p_resu_d;
  logic [3:0]      p_flag_q,  p_flag_d;
  logic [2:0]      p_rd_q,    p_rd_d;
  logic            p_we_q,    p_we_d;
  logic [3:0]      p_fmask_q, p_fmask_d;
  logic [3:0]      flags_q,   flags_d;
  logic [15:0]     count_q,   count_d;
  logic [bits-1:0] rf_q [8];
  logic            rf_we;
  logic            accept;

  assign IN_READY = !pvalid_q || !HOLD;
  assign WB_VALID = pvalid_q && !HOLD;
  assign accept   = IN_VALID && IN_READY;
  assign FLAGS    = flags_q;
  assign WB_COUNT = count_q;

  always_comb begin
    pvalid_d  = pvalid_q;
    p_resu_d  = p_resu_q;
    p_flag_d  = p_flag_q;
    p_rd_d    = p_rd_q;
    p_we_d    = p_we_q;
    p_fmask_d = p_fmask_q;
    flags_d   = flags_q;
    count_d   = count_q;
    rf_we     = 1'b0;
    if (WB_VALID) begin
      pvalid_d = 1'b0;
      rf_we    = p_we_q && (p_rd_q != 3'd0);
      flags_d  = (flags_q & ~p_fmask_q) | (p_flag_q & p_fmask_q);
      count_d  = count_q + 16'd1;
    end
    // A same-cycle accept overrides the clear above, keeping throughput at 1/cycle.
    if (accept) begin
      pvalid_d  = 1'b1;
      p_resu_d  = RESU;
      p_flag_d  = {O, C, S, Z};
      p_rd_d    = RD;
      p_we_d    = WE;
      p_fmask_d = FMASK;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      pvalid_q  <= 1'b0;
      p_resu_q  <= '0;
      p_flag_q  <= '0;
      p_rd_q    <= '0;
      p_we_q    <= 1'b0;
      p_fmask_q <= '0;
      flags_q   <= '0;
      count_q   <= '0;
    end else begin
      pvalid_q  <= pvalid_d;
      p_resu_q  <= p_resu_d;
      p_flag_q  <= p_flag_d;
      p_rd_q    <= p_rd_d;
      p_we_q    <= p_we_d;
      p_fmask_q <= p_fmask_d;
      flags_q   <= flags_d;
      count_q   <= count_d;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < 8; i++) rf_q[i] <= '0;
    end else if (rf_we) begin
      rf_q[p_rd_q] <= p_resu_q;
    end
  end

  // The pending value is already committed, so it forwards even while HOLD stalls it.
  always_comb begin
    RD1 = rf_q[RA1];
    if (RA1 == 3'd0)                                 RD1 = '0;
    else if (pvalid_q && p_we_q && (p_rd_q == RA1)) RD1 = p_resu_q;
  end

  always_comb begin
    RD2 = rf_q[RA2];
    if (RA2 == 3'd0)                                 RD2 = '0;
    else if (pvalid_q && p_we_q && (p_rd_q == RA2)) RD2 = p_resu_q;
  end

endmodule

// File: tb/tb_ula_wb.sv
// Directed bench for ula_wb: a table of per-cycle vectors plus hand sequences
// for asynchronous reset and WB_COUNT wrap-around.
module tb_ula_wb;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] resu;
  logic        o_f, c_f, s_f, z_f;
  logic [2:0]  rd;
  logic        we;
  logic [3:0]  fmask;
  logic        hold;
  logic [2:0]  ra1, ra2;
  logic [15:0] rd1, rd2;
  logic [3:0]  flags;
  logic        wb_valid;
  logic [15:0] wb_count;

  int n_tests = 0;
  int n_fail  = 0;

  ula_wb #(.bits(16)) dut (
    .CLK(clk), .RST(rst), .IN_VALID(in_valid), .IN_READY(in_ready),
    .RESU(resu), .O(o_f), .C(c_f), .S(s_f), .Z(z_f), .RD(rd), .WE(we),
    .FMASK(fmask), .HOLD(hold), .RA1(ra1), .RA2(ra2), .RD1(rd1), .RD2(rd2),
    .FLAGS(flags), .WB_VALID(wb_valid), .WB_COUNT(wb_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        iv;
    logic [15:0] resu;
    logic [3:0]  ocsz;
    logic [2:0]  rd;
    logic        we;
    logic [3:0]  fm;
    logic        hold;
    logic [2:0]  ra1;
    logic [2:0]  ra2;
    logic        e_rdy;
    logic        e_wbv;
    logic [15:0] e_rd1;
    logic [15:0] e_rd2;
    logic [3:0]  e_flags;
    logic [15:0] e_cnt;
  } vec_t;

  vec_t tbl [24];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive_idle();
    in_valid = 1'b0; resu = '0; {o_f, c_f, s_f, z_f} = 4'b0000;
    rd = '0; we = 1'b0; fmask = '0; hold = 1'b0; ra1 = '0; ra2 = '0;
  endtask

  task automatic check_all(input string tag, input logic e_rdy, input logic e_wbv,
                           input logic [15:0] e_rd1, input logic [15:0] e_rd2,
                           input logic [3:0] e_flags, input logic [15:0] e_cnt);
    check({tag, " in_ready"}, 32'(in_ready), 32'(e_rdy));
    check({tag, " wb_valid"}, 32'(wb_valid), 32'(e_wbv));
    check({tag, " rd1"},      32'(rd1),      32'(e_rd1));
    check({tag, " rd2"},      32'(rd2),      32'(e_rd2));
    check({tag, " flags"},    32'(flags),    32'(e_flags));
    check({tag, " wb_count"}, 32'(wb_count), 32'(e_cnt));
  endtask

  initial begin
    // Fields: iv, resu, {O,C,S,Z}, rd, we, fmask, hold, ra1, ra2 |
    //         in_ready, wb_valid, rd1, rd2, flags, wb_count (sampled before the edge)
    // Accept 1234 -> R3 with S=1, fmask {S,Z}; retire next cycle.
    tbl[0]  = '{1, 16'h1234, 4'b0010, 3, 1, 4'b0011, 0, 3, 0, 1, 0, 16'h0000, 16'h0000, 4'b0000, 0};
    tbl[1]  = '{0, 16'h0000, 4'b0000, 0, 0, 4'b0000, 0, 3, 0, 1, 1, 16'h1234, 16'h0000, 4'b0000, 0};
    tbl[2]  = '{0, 16'h0000, 4'b0000, 0, 0, 4'b0000, 0, 3, 0, 1, 0, 16'h1234, 16'h0000, 4'b0010, 1};
    // 00FF -> R5 held by HOLD for three cycles; a blocked IN_VALID is ignored.
    tbl[3]  = '{1, 16'h00FF, 4'b1111, 5, 1, 4'b0000, 0, 5, 3, 1, 0, 16'h0000, 16'h1234, 4'b0010, 1};
    tbl[4]  = '{0, 16'h0000, 4'b0000, 0, 0, 4'b0000, 1, 5, 3, 0, 0, 16'h00FF, 16'h1234, 4'b0010, 1};
    tbl[5]  = '{1, 16'h7777, 4'b1111, 5, 1, 4'b1111, 1, 5, 3, 0, 0, 16'h00FF, 16'h1234, 4'b0010, 1};
    tbl[6]  = '{0, 16'h0000, 4'b0000, 0, 0, 4'b0000, 1, 5, 3, 0, 0, 16'h00FF, 16'h1234, 4'b0010, 1};
    tbl[7]  = '{0, 16'h0000, 4'b0000, 0, 0, 4'b0000, 0, 5, 3, 1, 1, 16'h00FF, 16'h1234, 4'b0010, 1};
    tbl[8]  = '{0, 16'h0000, 4'b0000, 0, 0, 4'b0000, 0, 5, 3, 1, 0, 16'h00FF, 16'h1234, 4'b0010, 2};
    // BEEF -> R0 is dropped; its flags (all masked in) still land.
    tbl[9]  = '{1, 16'hBEEF, 4'b1101, 0, 1, 4'b1111, 0, 0, 3, 1, 0, 16'h0000, 16'h1234, 4'b0010, 2};
    tbl[10] = '{0, 16'h0000, 4'b0000, 0, 0, 4'b0000, 0, 0, 0, 1, 1, 16'h0000, 16'h0000, 4'b0010, 2};
    tbl[11] = '{0, 16'h0000, 4'b0000, 0, 0, 4'b0000, 0, 0, 5, 1, 0, 16'h0000, 16'h00FF, 4'b1101, 3};
    // Back-to-back R1..R4 = 1..4: four consecutive retirements, count +4.
    tbl[12] = '{1, 16'h0001, 4'b0000, 1, 1, 4'b0000, 0, 0, 4, 1, 0, 16'h0000, 16'h0000, 4'b1101, 3};
    tbl[13] = '{1, 16'h0002, 4'b0000, 2, 1, 4'b0000, 0, 1, 4, 1, 1, 16'h0001, 16'h0000, 4'b1101, 3};
    tbl[14] = '{1, 16'h0003, 4'b0000, 3, 1, 4'b0000, 0, 2, 4, 1, 1, 16'h0002, 16'h0000, 4'b1101, 4};
    tbl[15] = '{1, 16'h0004, 4'b0000, 4, 1, 4'b0000, 0, 3, 4, 1, 1, 16'h0003, 16'h0000, 4'b1101, 5};
    tbl[16] = '{0, 16'h0000, 4'b0000, 0, 0, 4'b0000, 0, 1, 4, 1, 1, 16'h0001, 16'h0004, 4'b1101, 6};
    tbl[17] = '{0, 16'h0000, 4'b0000, 0, 0, 4'b0000, 0, 2, 4, 1, 0, 16'h0002, 16'h0004, 4'b1101, 7};
    // WE=0, FMASK=0: retires and counts, no forwarding, no state change.
    tbl[18] = '{1, 16'hAAAA, 4'b0000, 2, 0, 4'b0000, 0, 2, 3, 1, 0, 16'h0002, 16'h0003, 4'b1101, 7};
    tbl[19] = '{0, 16'h0000, 4'b0000, 0, 0, 4'b0000, 0, 2, 3, 1, 1, 16'h0002, 16'h0003, 4'b1101, 7};
    tbl[20] = '{0, 16'h0000, 4'b0000, 0, 0, 4'b0000, 0, 2, 3, 1, 0, 16'h0002, 16'h0003, 4'b1101, 8};
    // Only C enabled: C cleared, O/S/Z keep their values despite differing inputs.
    tbl[21] = '{1, 16'h0000, 4'b1011, 1, 0, 4'b0100, 0, 1, 5, 1, 0, 16'h0001, 16'h00FF, 4'b1101, 8};
    tbl[22] = '{0, 16'h0000, 4'b0000, 0, 0, 4'b0000, 0, 1, 5, 1, 1, 16'h0001, 16'h00FF, 4'b1101, 8};
    tbl[23] = '{0, 16'h0000, 4'b0000, 0, 0, 4'b0000, 0, 1, 5, 1, 0, 16'h0001, 16'h00FF, 4'b1001, 9};

    // Reset block
    drive_idle();
    rst = 1'b1;
    #12;
    check_all("in_reset", 1'b1, 1'b0, 16'h0000, 16'h0000, 4'b0000, 16'h0000);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    ra1 = 3'd3; ra2 = 3'd7;
    @(negedge clk);
    check_all("post_reset", 1'b1, 1'b0, 16'h0000, 16'h0000, 4'b0000, 16'h0000);
    @(posedge clk); #1;

    // Table-driven vectors
    for (int i = 0; i < 24; i++) begin
      in_valid = tbl[i].iv; resu = tbl[i].resu; {o_f, c_f, s_f, z_f} = tbl[i].ocsz;
      rd = tbl[i].rd; we = tbl[i].we; fmask = tbl[i].fm; hold = tbl[i].hold;
      ra1 = tbl[i].ra1; ra2 = tbl[i].ra2;
      @(negedge clk);
      check_all($sformatf("v%0d", i), tbl[i].e_rdy, tbl[i].e_wbv, tbl[i].e_rd1,
                tbl[i].e_rd2, tbl[i].e_flags, tbl[i].e_cnt);
      @(posedge clk); #1;
    end

    // Async reset between edges while an entry to R2 is pending (R2 holds 2 from the table).
    in_valid = 1'b1; resu = 16'h5555; {o_f, c_f, s_f, z_f} = 4'b1111;
    rd = 3'd2; we = 1'b1; fmask = 4'b1111; hold = 1'b0; ra1 = 3'd2; ra2 = 3'd3;
    @(posedge clk); #1;
    in_valid = 1'b0; hold = 1'b1;
    #1;
    check("pend_before_rst in_ready", 32'(in_ready), 32'd0);
    check("pend_before_rst rd1",      32'(rd1),      32'h5555);
    #1;
    rst = 1'b1;
    #1;
    check_all("mid_rst", 1'b1, 1'b0, 16'h0000, 16'h0000, 4'b0000, 16'h0000);
    @(negedge clk);
    rst = 1'b0; hold = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      @(negedge clk);
      check_all($sformatf("after_rst%0d", k), 1'b1, 1'b0, 16'h0000, 16'h0000, 4'b0000, 16'h0000);
    end

    // WB_COUNT wrap: 65535 retirements, then one more.
    @(posedge clk); #1;
    drive_idle();
    in_valid = 1'b1;
    repeat (65535) @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    check("wrap_pre wb_count", 32'(wb_count), 32'h0000FFFF);
    check("wrap_pre wb_valid", 32'(wb_valid), 32'd0);
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("wrap_last wb_valid", 32'(wb_valid), 32'd1);
    check("wrap_last wb_count", 32'(wb_count), 32'h0000FFFF);
    @(posedge clk); #1;
    check("wrap_post wb_count", 32'(wb_count), 32'h00000000);
    check("wrap_post wb_valid", 32'(wb_valid), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ula_wb.md
ULA_WB -- requirements
Module: ula_wb

Interface
REQ-001 SHALL provide parameter: bits, 16, data width of ULA result and register file entries.
REQ-002 SHALL provide port: CLK  input  1  single clock, all state on rising edge.
REQ-003 SHALL provide port: RST  input  1  reset, asynchronous, active-high.
REQ-004 SHALL provide port: IN_VALID  input  1  execute stage presents a result.
REQ-005 SHALL provide port: IN_READY  output  1  stage can accept a result this cycle.
REQ-006 SHALL provide port: RESU  input  bits  ULA result.
REQ-007 SHALL provide ports: O, C, S, Z  input  1 each  ULA overflow, carry, sign, zero flags.
REQ-008 SHALL provide port: RD  input  3  destination register index.
REQ-009 SHALL provide port: WE  input  1  write RESU to register RD.
REQ-010 SHALL provide port: FMASK  input  4  per-flag update enable, bit order {O,C,S,Z}.
REQ-011 SHALL provide port: HOLD  input  1  external stall, blocks retirement.
REQ-012 SHALL provide ports: RA1, RA2  input  3  operand read addresses (feed ULA A/B).
REQ-013 SHALL provide ports: RD1, RD2  output  bits  operand read data.
REQ-014 SHALL provide port: FLAGS  output  4  architectural flags {O,C,S,Z}.
REQ-015 SHALL provide port: WB_VALID  output  1  retirement occurring this cycle.
REQ-016 SHALL provide port: WB_COUNT  output  16  retired-entry counter.

Function
REQ-017 SHALL contain one pending-entry register (pvalid plus captured RESU, O/C/S/Z, RD, WE, FMASK) and an 8 x bits register file.
REQ-018 SHALL drive IN_READY = !pvalid | !HOLD (combinational).
REQ-019 SHALL capture inputs into pending entry on rising edge when IN_VALID & IN_READY; no capture otherwise.
REQ-020 SHALL retire pending entry when pvalid & !HOLD; WB_VALID = pvalid & !HOLD, combinational.
REQ-021 SHALL on retirement write captured RESU to register RD when WE=1 and RD!=0; register 0 always reads 0, writes ignored.
REQ-022 SHALL on retirement load each FLAGS bit from captured flag where FMASK bit=1; bits with FMASK=0 unchanged.
REQ-023 SHALL support retire and accept in the same cycle (throughput 1/cycle); pvalid stays 1, new entry replaces old.
REQ-024 SHALL clear pvalid on retirement without accept; hold pending entry unchanged while HOLD=1.
REQ-025 SHALL make RD1/RD2 combinational: 0 if address 0; else pending RESU if pvalid & pending WE & pending RD equals address; else register file contents.
REQ-026 SHALL forward pending RESU regardless of HOLD (value is committed, only delayed).
REQ-027 SHALL increment WB_COUNT by 1 per retirement, wrapping 16'hFFFF -> 16'h0000.
REQ-028 SHALL ignore RESU/flag/RD/WE/FMASK values when not capturing; IN_VALID=1 with IN_READY=0 SHALL leave state unchanged.
REQ-029 SHALL accept a result with WE=0 and FMASK=0 (counts as retirement, no architectural change).

Reset
REQ-030 SHALL on RST=1 immediately clear pvalid, all 8 registers, FLAGS and WB_COUNT to 0, independent of CLK.
REQ-031 SHALL discard any pending entry when RST asserts mid-operation; no write, flag update or count occurs.
REQ-032 SHALL after RST release present IN_READY=1, WB_VALID=0, RD1=RD2=0, FLAGS=4'b0000, WB_COUNT=0.

Verification
REQ-033 Bench SHALL cover: accept RESU=16'h1234, RD=3, WE=1, FMASK=4'b0011, Z=0,S=1, HOLD=0 -> next cycle WB_VALID=1, then R3=16'h1234, FLAGS=4'b0010, WB_COUNT=1.
REQ-034 Bench SHALL cover: pending RESU=16'h00FF to RD=5, HOLD=1 for 3 cycles, RA1=5 -> RD1=16'h00FF throughout, IN_READY=0, WB_COUNT unchanged until HOLD=0.
REQ-035 Bench SHALL cover: write RESU=16'hBEEF to RD=0 with WE=1 -> RA1=0 reads 16'h0000 before and after retirement.
REQ-036 Bench SHALL cover: back-to-back IN_VALID for 4 cycles writing R1..R4 = 1..4, HOLD=0 -> WB_VALID high 4 consecutive cycles, WB_COUNT=4, RA2=4 forwards 4 in last cycle.
REQ-037 Bench SHALL cover: preload WB_COUNT to 16'hFFFF via 65535 retirements, one more -> WB_COUNT=16'h0000.
REQ-038 Bench SHALL cover: RST asserted between edges while entry to R2 pending -> pvalid=0 immediately, R2=0, FLAGS=0, no WB_VALID after release.
